// File: rtl/lag_measure_sequencer_if.sv
// Bundle between the lag measurement sequencer and its trigger,
// sensor and display neighbours.
interface lag_measure_sequencer_if #(
  parameter int AVG_LOG2 = 5
);
  logic                mode_change;
  logic                start_pulse;
  logic                sensor;
  logic                busy;
  logic [19:0]         last_us;
  logic [19:0]         min_us;
  logic [19:0]         max_us;
  logic [19:0]         avg_us;
  logic [AVG_LOG2-1:0] sample_count;
  logic                result_valid;
  logic                avg_valid;
  logic                timeout;

  modport master (
    output mode_change, start_pulse, sensor,
    input  busy, last_us, min_us, max_us, avg_us,
    input  sample_count, result_valid, avg_valid, timeout
  );

  modport slave (
    input  mode_change, start_pulse, sensor,
    output busy, last_us, min_us, max_us, avg_us,
    output sample_count, result_valid, avg_valid, timeout
  );
endinterface

// File: rtl/lag_measure_sequencer.sv
// One lag measurement per flash: start arms a microsecond timer,
// the next sensor rising edge or a timeout ends it; keeps stats.
module lag_measure_sequencer #(
  parameter int CLOCK_DIVIDER = 27,
  parameter int MAX_US        = 999999,
  parameter int AVG_LOG2      = 5
) (
  input  logic clock,
  input  logic reset_n,
  lag_measure_sequencer_if.slave bus
);
  localparam int DW = (CLOCK_DIVIDER > 1) ?
                      $clog2(CLOCK_DIVIDER) : 1;
  localparam int AW = 20 + AVG_LOG2;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLOCK_DIVIDER - 1);
  localparam logic [19:0]   MAXV     = 20'(MAX_US);

  typedef enum logic [1:0] {
    S_IDLE, S_MEASURE, S_DONE, S_TOUT
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_sensor_d;
  logic [DW-1:0]       r_div;
  logic [19:0]         r_us;
  logic [19:0]         r_result;
  logic [AW-1:0]       r_acc;
  logic [AVG_LOG2-1:0] r_cnt;
  logic                r_busy;
  logic [19:0]         r_last;
  logic [19:0]         r_min;
  logic [19:0]         r_max;
  logic [19:0]         r_avg;
  logic                r_rv;
  logic                r_av;
  logic                r_tout;

  logic          w_edge;
  logic          w_tick;
  logic          w_expire;
  logic [AW-1:0] w_sum;

  assign w_edge   = bus.sensor & ~r_sensor_d;
  assign w_tick   = (r_div == DIV_LAST);
  assign w_expire = w_tick && (r_us == MAXV);
  assign w_sum    = r_acc + AW'(r_result);

  always_ff @(posedge clock) begin
    if (!reset_n) r_sensor_d <= 1'b0;
    else          r_sensor_d <= bus.sensor;
  end

  always_ff @(posedge clock) begin
    if (!reset_n || bus.mode_change) r_state <= S_IDLE;
    else                             r_state <= w_next;
  end

  // Edge beats restart, restart beats timeout.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (bus.start_pulse) w_next = S_MEASURE;
      S_MEASURE:
        if (w_edge)                w_next = S_DONE;
        else if (bus.start_pulse)  w_next = S_MEASURE;
        else if (w_expire)         w_next = S_TOUT;
      S_DONE:  w_next = S_IDLE;
      S_TOUT:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n || bus.mode_change) begin
      r_div    <= '0;
      r_us     <= '0;
      r_result <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_last   <= MAXV;
      r_min    <= MAXV;
      r_max    <= '0;
      r_avg    <= MAXV;
      r_rv     <= 1'b0;
      r_av     <= 1'b0;
      r_tout   <= 1'b0;
    end else begin
      r_rv <= 1'b0;
      r_av <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start_pulse) begin
            r_div  <= '0;
            r_us   <= '0;
            r_busy <= 1'b1;
          end
        end
        S_MEASURE: begin
          if (w_edge) begin
            r_result <= r_us;
            r_busy   <= 1'b0;
          end else if (bus.start_pulse) begin
            r_div <= '0;
            r_us  <= '0;
          end else if (w_tick) begin
            r_div <= '0;
            r_us  <= r_us + 20'd1;
            if (w_expire) r_busy <= 1'b0;
          end else begin
            r_div <= r_div + DW'(1);
          end
        end
        S_DONE: begin
          r_last <= r_result;
          r_rv   <= 1'b1;
          r_tout <= 1'b0;
          if (r_result < r_min) r_min <= r_result;
          if (r_result > r_max) r_max <= r_result;
          // Window full: this sample completes the average.
          if (&r_cnt) begin
            r_avg <= w_sum[AW-1:AVG_LOG2];
            r_av  <= 1'b1;
            r_acc <= '0;
            r_cnt <= '0;
          end else begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + AVG_LOG2'(1);
          end
        end
        S_TOUT: begin
          r_last <= MAXV;
          r_rv   <= 1'b1;
          r_tout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.last_us      = r_last;
  assign bus.min_us       = r_min;
  assign bus.max_us       = r_max;
  assign bus.avg_us       = r_avg;
  assign bus.sample_count = r_cnt;
  assign bus.result_valid = r_rv;
  assign bus.avg_valid    = r_av;
  assign bus.timeout      = r_tout;
endmodule
